// File: rtl/mdu_ctrl_if.sv
// rtl/mdu_ctrl_if.sv - EX-stage to multiply/divide unit bus with master/slave views
//
// Purpose: groups the operation request (Start/MDUOp/A/B/Cancel) driven by the
// EX stage and the Busy/HI/LO state returned by the multiply/divide unit.
// Signals:
//   Start   1   op valid this cycle
//   MDUOp   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   A       32  rs operand
//   B       32  rt operand
//   Cancel  1   abort any in-flight mult/div
//   Busy    1   mult/div in flight
//   HI      32  architectural HI
//   LO      32  architectural LO
// Modports: master = EX stage side, slave = multiply/divide unit side.

interface mdu_ctrl_if;
    logic        Start;
    logic [2:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cancel;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output Start, MDUOp, A, B, Cancel,
        input  Busy, HI, LO
    );

    modport slave (
        input  Start, MDUOp, A, B, Cancel,
        output Busy, HI, LO
    );
endinterface

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multi-cycle multiply/divide unit owning the HI/LO registers
//
// Purpose: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX. The full result is
// computed when the op is accepted and held in pending registers; it is
// committed to HI/LO after a fixed busy period, so the hazard unit sees the
// same latency as an iterative unit. Cancel aborts the busy period without
// touching HI/LO.
// Ports:
//   clk     in   1   rising-edge clock
//   reset   in   1   asynchronous, active-low
//   bus     slave modport of mdu_ctrl_if (Start/MDUOp/A/B/Cancel in,
//                   Busy/HI/LO out, all outputs registered)
// Parameters:
//   MULT_CYCLES  busy cycles for MULT/MULTU (>=1)
//   DIV_CYCLES   busy cycles for DIV/DIVU (>=1)

module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    mdu_ctrl_if.slave   bus
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;

    logic [31:0]   r_hi;
    logic [31:0]   r_lo;
    logic [31:0]   r_pend_hi;
    logic [31:0]   r_pend_lo;
    // Cleared for divide-by-zero so the commit leaves HI/LO untouched.
    logic          r_pend_ok;

    logic          w_ld_mul;
    logic          w_ld_div;
    logic          w_commit;
    logic          w_mthi;
    logic          w_mtlo;

    // ---------------- multiply ----------------
    // Sign-extending (MULT) or zero-extending (MULTU) to 64 bits lets one
    // unsigned 64-bit multiplier produce the correct low 64 bits for both.
    logic        w_mul_sgn;
    logic [63:0] w_prod;

    assign w_mul_sgn = ~bus.MDUOp[0];
    assign w_prod    = {{32{w_mul_sgn & bus.A[31]}}, bus.A}
                     * {{32{w_mul_sgn & bus.B[31]}}, bus.B};

    // ---------------- divide ----------------
    // Signed divide runs on magnitudes and fixes signs afterwards: quotient
    // negative when operand signs differ, remainder follows the dividend.
    // The 0x80000000 / -1 case falls out naturally as quotient 0x80000000.
    logic        w_div_sgn;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_div_zero;

    assign w_div_sgn  = ~bus.MDUOp[0];
    assign w_a_neg    = w_div_sgn & bus.A[31];
    assign w_b_neg    = w_div_sgn & bus.B[31];
    assign w_a_mag    = w_a_neg ? (32'd0 - bus.A) : bus.A;
    assign w_b_mag    = w_b_neg ? (32'd0 - bus.B) : bus.B;
    assign w_div_zero = (bus.B == 32'd0);
    // Keeps the divider away from a zero divisor; the result is discarded anyway.
    assign w_b_safe   = w_div_zero ? 32'd1 : w_b_mag;
    assign w_q_mag    = w_a_mag / w_b_safe;
    assign w_r_mag    = w_a_mag % w_b_safe;
    assign w_quot     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_rem      = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ld_mul    = 1'b0;
        w_ld_div    = 1'b0;
        w_commit    = 1'b0;
        w_mthi      = 1'b0;
        w_mtlo      = 1'b0;
        case (r_state)
            IDLE: begin
                // Cancel in IDLE drops a same-cycle Start.
                if (bus.Start && !bus.Cancel) begin
                    case (bus.MDUOp)
                        3'd0, 3'd1: begin
                            w_ld_mul    = 1'b1;
                            w_state_nxt = MUL_RUN;
                            w_cnt_nxt   = CW'(MULT_CYCLES - 1);
                        end
                        3'd2, 3'd3: begin
                            w_ld_div    = 1'b1;
                            w_state_nxt = DIV_RUN;
                            w_cnt_nxt   = CW'(DIV_CYCLES - 1);
                        end
                        3'd4:    w_mthi = 1'b1;
                        3'd5:    w_mtlo = 1'b1;
                        default: ;
                    endcase
                end
            end
            MUL_RUN, DIV_RUN: begin
                // Start is ignored here; the hazard unit never issues one.
                if (bus.Cancel) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == '0) begin
                    w_commit    = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ---------------- HI/LO and pending results ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_ok <= 1'b0;
        end else begin
            if (w_ld_mul) begin
                r_pend_hi <= w_prod[63:32];
                r_pend_lo <= w_prod[31:0];
                r_pend_ok <= 1'b1;
            end else if (w_ld_div) begin
                r_pend_hi <= w_rem;
                r_pend_lo <= w_quot;
                r_pend_ok <= ~w_div_zero;
            end
            if (w_commit && r_pend_ok) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
            if (w_mthi) begin
                r_hi <= bus.A;
            end
            if (w_mtlo) begin
                r_lo <= bus.A;
            end
        end
    end

    assign bus.Busy = (r_state != IDLE);
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - scoreboard bench for mdu_ctrl

module tb_mdu_ctrl;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    mdu_ctrl_if u_if ();

    mdu_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        int          lat;
        int          due;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a busy period ending pops a multi-cycle expectation; a
    // zero-latency expectation is checked on the cycle after its issue.
    int   bcnt;
    exp_t e;
    always @(negedge clk) begin
        if (!reset) begin
            bcnt = 0;
        end else begin
            if (u_if.Busy) begin
                bcnt++;
            end else if (bcnt > 0) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'(bcnt), 32'd0);
                end else begin
                    e = q.pop_front();
                    chk({e.name, "_busy_len"}, 32'(bcnt), 32'(e.lat));
                    chk({e.name, "_hi"}, u_if.HI, e.hi);
                    chk({e.name, "_lo"}, u_if.LO, e.lo);
                end
                bcnt = 0;
            end else if (q.size() > 0 && q[0].lat == 0 && cyc >= q[0].due) begin
                e = q.pop_front();
                chk({e.name, "_busy"}, {31'd0, u_if.Busy}, 32'd0);
                chk({e.name, "_hi"}, u_if.HI, e.hi);
                chk({e.name, "_lo"}, u_if.LO, e.lo);
            end
            if (q.size() > 0 && cyc > q[0].due + q[0].lat + 20) begin
                e = q.pop_front();
                chk({e.name, "_timeout"}, 32'd1, 32'd0);
            end
        end
    end

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cancel);
        u_if.Start  = 1'b1;
        u_if.MDUOp  = op;
        u_if.A      = a;
        u_if.B      = b;
        u_if.Cancel = cancel;
        @(posedge clk);
        #1;
        u_if.Start  = 1'b0;
        u_if.Cancel = 1'b0;
    endtask

    task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic cancel, input int lat,
                         input logic [31:0] ehi, input logic [31:0] elo);
        exp_t x;
        x.name = name;
        x.lat  = lat;
        x.due  = cyc + 1;
        x.hi   = ehi;
        x.lo   = elo;
        q.push_back(x);
        drive(op, a, b, cancel);
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge clk);
        #1;
        if (q.size() != 0) begin
            chk({name, "_drain_timeout"}, 32'(q.size()), 32'd0);
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        cyc         = 0;
        bcnt        = 0;
        reset       = 1'b0;
        u_if.Start  = 1'b0;
        u_if.MDUOp  = 3'd7;
        u_if.A      = '0;
        u_if.B      = '0;
        u_if.Cancel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, u_if.Busy}, 32'd0);
        chk("reset_hi", u_if.HI, 32'd0);
        chk("reset_lo", u_if.LO, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        issue("mult_neg", 3'd0, 32'hFFFFFFFD, 32'd5, 1'b0, 5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        wait_empty("mult_neg");
        issue("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 5, 32'hFFFFFFFE, 32'h00000001);
        wait_empty("multu_max");
        issue("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        wait_empty("div_neg");
        issue("divu", 3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 10, 32'h00000001, 32'h7FFFFFFC);
        wait_empty("divu");
        issue("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10, 32'h0, 32'h80000000);
        wait_empty("div_ovf");
        // -7 / -2 = 3 rem -1
        issue("div_nn", 3'd2, 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b0, 10, 32'hFFFFFFFF, 32'h00000003);
        wait_empty("div_nn");
        // 7 / -2 = -3 rem 1
        issue("div_pn", 3'd2, 32'd7, 32'hFFFFFFFE, 1'b0, 10, 32'h00000001, 32'hFFFFFFFD);
        wait_empty("div_pn");

        issue("mthi", 3'd4, 32'h0000ABCD, 32'd0, 1'b0, 0, 32'h0000ABCD, 32'hFFFFFFFD);
        wait_empty("mthi");
        issue("mthi_11", 3'd4, 32'h11, 32'd0, 1'b0, 0, 32'h11, 32'hFFFFFFFD);
        wait_empty("mthi_11");
        issue("mtlo_22", 3'd5, 32'h22, 32'd0, 1'b0, 0, 32'h11, 32'h22);
        wait_empty("mtlo_22");
        issue("noop", 3'd6, 32'h12345678, 32'd9, 1'b0, 0, 32'h11, 32'h22);
        wait_empty("noop");

        // Divide by zero; MTHI/MTLO/MULT issued while busy must be ignored.
        issue("divu_zero", 3'd3, 32'd5, 32'd0, 1'b0, 10, 32'h11, 32'h22);
        drive(3'd4, 32'h5555, 32'd0, 1'b0);
        drive(3'd5, 32'h6666, 32'd0, 1'b0);
        drive(3'd0, 32'd3, 32'd3, 1'b0);
        wait_empty("divu_zero");

        // Cancel in the third busy cycle of a DIV.
        issue("div_cancel", 3'd2, 32'd100, 32'd7, 1'b0, 3, 32'h11, 32'h22);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        u_if.Cancel = 1'b1;
        @(posedge clk);
        #1;
        u_if.Cancel = 1'b0;
        wait_empty("div_cancel");

        // Cancel with Start in IDLE drops the Start.
        issue("cancel_mthi", 3'd4, 32'h99, 32'd0, 1'b1, 0, 32'h11, 32'h22);
        wait_empty("cancel_mthi");
        issue("cancel_mult", 3'd0, 32'd6, 32'd7, 1'b1, 0, 32'h11, 32'h22);
        wait_empty("cancel_mult");

        // Asynchronous reset in the middle of a MULT.
        drive(3'd0, 32'd6, 32'd7, 1'b0);
        @(posedge clk);
        #2;
        chk("pre_rst_busy", {31'd0, u_if.Busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_mid_busy", {31'd0, u_if.Busy}, 32'd0);
        chk("rst_mid_hi", u_if.HI, 32'd0);
        chk("rst_mid_lo", u_if.LO, 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_busy", {31'd0, u_if.Busy}, 32'd0);
        chk("post_rst_hi", u_if.HI, 32'd0);
        chk("post_rst_lo", u_if.LO, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
